ssd_frame_receiver: RTL and testbench
=====================================

// Module: ssd_frame_receiver
// PURPOSE
// - Receiving end of the digit-scan stream (shift_strobe/display_char/ssd_en) produced by the writeback display scanner.
// - Reassembles 8 nibbles into a frame; commits it to a display buffer when the frame ends cleanly.
// - Time-multiplexes the committed frame onto an 8-digit common-anode seven-segment display with hex decode.
// PARAMETERS
// - REFRESH_DIV  100000  clk cycles per digit slot (>=2); 100 MHz -> 1 kHz digit, 125 Hz frame
// PORTS
// - clk           in   1  clock
// - n_rst         in   1  reset, asynchronous, active-low
// - shift_strobe  in   1  end-of-frame marker, valid with the digit-0 beat
// - display_char  in   4  nibble for the digit selected by ssd_en
// - ssd_en        in   8  one-hot digit select; bit 7 = most significant nibble; 0 = no beat
// - seg           out  7  segments {g,f,e,d,c,b,a}, active-low
// - an            out  8  digit anodes, active-low, an[i] drives digit i
// - frame_valid   out  1  high once any frame has committed; sticky until reset
// - frame_err     out  1  one-cycle pulse on protocol error
// BEHAVIOUR
// - Reset: seg=7'h7F, an=8'hFF, frame_valid=0, frame_err=0, shadow and display buffers=0, scan_idx=0, refresh count=0, RX FSM=R_IDLE.
// - Beat: any cycle with ssd_en!=0. Non-one-hot ssd_en = error. Nibble sampled same cycle as ssd_en.
// - RX FSM, expected index exp:
//   R_IDLE: ssd_en==8'h80 -> store shadow[7], exp=6, R_RECV; any other beat -> frame_err, stay.
//   R_RECV: ssd_en==1<<exp -> store shadow[exp], exp--; on exp==0 beat: strobe=1 -> commit, R_IDLE; strobe=0 -> frame_err, R_IDLE.
//   R_RECV: ssd_en==8'h80 (restart) -> frame_err, drop partial, store shadow[7], exp=6, stay R_RECV.
//   R_RECV: any other beat (wrong index, non-one-hot) -> frame_err, R_IDLE.
//   shift_strobe without a digit-0 beat, in any state -> frame_err, state unchanged.
//   No-beat cycles are idle gaps; no timeout.
// - Commit: display[7:0] <= shadow with digit-0 nibble merged, in the cycle after the beat; frame_valid=1 from the same cycle.
// - Errored frames never alter display; frame_err registered, at most one pulse per cycle.
// - Scan: counter 0..REFRESH_DIV-1; at wrap scan_idx = (scan_idx+1) mod 8.
// - seg/an are registered from scan_idx and display: 1-cycle latency; a commit shows on seg 2 cycles after the digit-0 beat when that digit is scanned.
// - frame_valid=0: an=8'hFF, seg=7'h7F (blanked). Else an=~(8'b1<<scan_idx), seg=decode(display[scan_idx]).
// - Decode 0-F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
// - Commit and scan wrap in the same cycle: both take effect; no glitch beyond the normal 1-cycle latency.
// - Reset mid-frame or mid-scan: everything returns to reset values immediately; the partial frame is lost.
// CONFIGURATION
// - SSD_LZ_BLANK_EN defined: leading zero digits blanked (seg=7'h7F, anode still scanned). Digit i (7..1) is blanked
//   when display[7:i] are all zero. Digit 0 is never blanked.
// - SSD_LZ_BLANK_EN undefined: every digit decoded, zeros shown as 7'h40.
// TESTING (REFRESH_DIV=4)
// - Reset, no input -> an=8'hFF, seg=7'h7F, frame_valid=0 for 100 cycles.
// - Frame 0x1234ABCD, beats 7..0 back-to-back, strobe on last -> frame_valid=1; scan slot 0 seg=7'h21, slot 7 seg=7'h79; an cycles FE,FD,..,7F every 4 cycles.
// - Frame 0x12345678 then frame with ssd_en=8'h20 after 8'h80 -> one frame_err pulse; display stays 0x12345678.
// - Digit-0 beat without strobe -> frame_err, no commit; next clean frame 0xFFFFFFFF commits, all slots seg=7'h0E.
// - ssd_en=8'h81 -> frame_err; 3-cycle idle gaps between beats of a frame -> commits normally.
// - With SSD_LZ_BLANK_EN, frame 0x000000A0 -> slots 7..2 seg=7'h7F, slot 1 seg=7'h08, slot 0 seg=7'h40; without the macro, slots 7..2 seg=7'h40.

Source files
------------

// File: rtl/ssd_frame_receiver.sv
// Digit-scan stream receiver: rebuilds 8-nibble frames and scans them onto an 8-digit 7-seg display.
// Optional SSD_LZ_BLANK_EN blanks leading zero digits.
module ssd_frame_receiver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       shift_strobe,
  input  logic [3:0] display_char,
  input  logic [7:0] ssd_en,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    R_IDLE,
    R_RECV
  } rx_state_t;

  rx_state_t        r_state;
  logic [2:0]       r_exp;
  logic [7:0][3:0]  r_shadow;
  logic [7:0][3:0]  r_disp;
  logic             r_valid;
  logic             r_err;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_idx;
  logic [6:0]       r_seg;
  logic [7:0]       r_an;

  logic             w_beat;
  logic             w_d0;
  logic             w_wrap;
  logic [7:0]       w_exp_oh;
  logic [7:0]       w_blank;

  assign w_beat   = |ssd_en;
  assign w_d0     = (ssd_en == 8'h01);
  assign w_exp_oh = 8'b1 << r_exp;
  assign w_wrap   = (r_cnt == CW'(REFRESH_DIV - 1));

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'h0:    f_dec = 7'h40;
      4'h1:    f_dec = 7'h79;
      4'h2:    f_dec = 7'h24;
      4'h3:    f_dec = 7'h30;
      4'h4:    f_dec = 7'h19;
      4'h5:    f_dec = 7'h12;
      4'h6:    f_dec = 7'h02;
      4'h7:    f_dec = 7'h78;
      4'h8:    f_dec = 7'h00;
      4'h9:    f_dec = 7'h10;
      4'hA:    f_dec = 7'h08;
      4'hB:    f_dec = 7'h03;
      4'hC:    f_dec = 7'h46;
      4'hD:    f_dec = 7'h21;
      4'hE:    f_dec = 7'h06;
      default: f_dec = 7'h0E;
    endcase
  endfunction

  // A stray strobe is reported and the beat it rides on is ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= R_IDLE;
      r_exp    <= 3'd0;
      r_shadow <= '0;
      r_disp   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (shift_strobe && !w_d0) begin
        r_err <= 1'b1;
      end else if (w_beat) begin
        case (r_state)
          R_IDLE: begin
            if (ssd_en == 8'h80) begin
              r_shadow[7] <= display_char;
              r_exp       <= 3'd6;
              r_state     <= R_RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
          R_RECV: begin
            if (ssd_en == w_exp_oh) begin
              if (r_exp == 3'd0) begin
                r_state <= R_IDLE;
                if (shift_strobe) begin
                  r_disp  <= {r_shadow[7:1], display_char};
                  r_valid <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
              end else begin
                r_shadow[r_exp] <= display_char;
                r_exp           <= r_exp - 3'd1;
              end
            end else if (ssd_en == 8'h80) begin
              r_err       <= 1'b1;
              r_shadow    <= '0;
              r_shadow[7] <= display_char;
              r_exp       <= 3'd6;
            end else begin
              r_err   <= 1'b1;
              r_state <= R_IDLE;
            end
          end
          default: r_state <= R_IDLE;
        endcase
      end
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic [7:0] w_nz;

  always_comb begin
    w_nz = '0;
    for (int i = 0; i < 8; i++)
      w_nz[i] = |r_disp[i];
  end

  always_comb begin
    w_blank = '0;
    for (int i = 1; i < 8; i++)
      w_blank[i] = ((w_nz >> i) == 8'h00);
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_seg <= 7'h7F;
      r_an  <= 8'hFF;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (!r_valid) begin
        r_an  <= 8'hFF;
        r_seg <= 7'h7F;
      end else begin
        r_an  <= ~(8'b1 << r_idx);
        r_seg <= w_blank[r_idx] ? 7'h7F : f_dec(r_disp[r_idx]);
      end
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign frame_valid = r_valid;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_ssd_frame_receiver.sv
// Directed bench for ssd_frame_receiver at REFRESH_DIV=4.
// Define SSD_LZ_BLANK_EN for both DUT and bench to cover leading-zero blanking.
module tb_ssd_frame_receiver;

  logic       clk;
  logic       n_rst;
  logic       shift_strobe;
  logic [3:0] display_char;
  logic [7:0] ssd_en;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_valid;
  logic       frame_err;

  int checks;
  int failures;
  int errs;

  ssd_frame_receiver #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_strobe (shift_strobe),
    .display_char (display_char),
    .ssd_en       (ssd_en),
    .seg          (seg),
    .an           (an),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_err === 1'b1) errs++;

  task automatic idle();
    ssd_en       = 8'h00;
    display_char = 4'h0;
    shift_strobe = 1'b0;
  endtask

  task automatic beat(input logic [7:0] en, input logic [3:0] ch,
                      input logic st);
    @(negedge clk);
    ssd_en       = en;
    display_char = ch;
    shift_strobe = st;
    @(negedge clk);
    idle();
  endtask

  task automatic send_frame(input logic [31:0] d, input logic st,
                            input int gap);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      ssd_en       = 8'(1 << i);
      display_char = d[i*4 +: 4];
      shift_strobe = st && (i == 0);
      if (gap > 0) begin
        @(negedge clk);
        idle();
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic wait_slot(input int k, output bit ok);
    logic [7:0] tgt;
    tgt = ~(8'b1 << k);
    ok  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (an === tgt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    n_rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (an !== 8'hFF || seg !== 7'h7F || frame_valid !== 1'b0 ||
          frame_err !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle bad_cycles=%0d required=0 an=%h seg=%h",
               bad, an, seg);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int e0;
    logic [7:0] exp_an;
    e0 = errs;
    send_frame(32'h1234ABCD, 1'b1, 0);
    checks++;
    if (frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL commit_valid got=%b required=1", frame_valid);
    end
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h21) begin
      failures++;
      $display("FAIL f1_slot0 ok=%0d seg=%h required=21", ok, seg);
    end
    wait_slot(3, ok);
    checks++;
    if (!ok || seg !== 7'h08) begin
      failures++;
      $display("FAIL f1_slot3 ok=%0d seg=%h required=08", ok, seg);
    end
    wait_slot(7, ok);
    checks++;
    if (!ok || seg !== 7'h79) begin
      failures++;
      $display("FAIL f1_slot7 ok=%0d seg=%h required=79", ok, seg);
    end
    wait_slot(0, ok);
    for (int c = 0; c < 8 && an === 8'hFE; c++) @(negedge clk);
    exp_an = 8'hFD;
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL an_cycle step=%0d got=%h required=%h", s, an, exp_an);
      end
      exp_an = {exp_an[6:0], exp_an[7]};
      repeat (4) @(negedge clk);
    end
    checks++;
    if (errs - e0 !== 0) begin
      failures++;
      $display("FAIL f1_no_err got=%0d required=0", errs - e0);
    end
  endtask

  task automatic test_bad_index();
    bit ok;
    int e0;
    send_frame(32'h12345678, 1'b1, 0);
    e0 = errs;
    beat(8'h80, 4'h9, 1'b0);
    beat(8'h20, 4'h9, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (errs - e0 !== 1) begin
      failures++;
      $display("FAIL bad_index_err got=%0d required=1", errs - e0);
    end
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h00) begin
      failures++;
      $display("FAIL f2_slot0 ok=%0d seg=%h required=00", ok, seg);
    end
    wait_slot(6, ok);
    checks++;
    if (!ok || seg !== 7'h24) begin
      failures++;
      $display("FAIL f2_slot6 ok=%0d seg=%h required=24", ok, seg);
    end
  endtask

  task automatic test_no_strobe();
    bit ok;
    int e0;
    e0 = errs;
    send_frame(32'h00000000, 1'b0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (errs - e0 !== 1) begin
      failures++;
      $display("FAIL nostrobe_err got=%0d required=1", errs - e0);
    end
    wait_slot(7, ok);
    checks++;
    if (!ok || seg !== 7'h79) begin
      failures++;
      $display("FAIL nostrobe_keep ok=%0d seg=%h required=79", ok, seg);
    end
    e0 = errs;
    beat(8'h00, 4'h0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (errs - e0 !== 1) begin
      failures++;
      $display("FAIL lone_strobe_err got=%0d required=1", errs - e0);
    end
    send_frame(32'hFFFFFFFF, 1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      wait_slot(k, ok);
      checks++;
      if (!ok || seg !== 7'h0E) begin
        failures++;
        $display("FAIL ff_slot%0d ok=%0d seg=%h required=0E", k, ok, seg);
      end
    end
  endtask

  task automatic test_restart();
    bit ok;
    int e0;
    e0 = errs;
    beat(8'h80, 4'h3, 1'b0);
    beat(8'h40, 4'h3, 1'b0);
    send_frame(32'h87654321, 1'b1, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (errs - e0 !== 1) begin
      failures++;
      $display("FAIL restart_err got=%0d required=1", errs - e0);
    end
    wait_slot(7, ok);
    checks++;
    if (!ok || seg !== 7'h00) begin
      failures++;
      $display("FAIL restart_slot7 ok=%0d seg=%h required=00", ok, seg);
    end
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h79) begin
      failures++;
      $display("FAIL restart_slot0 ok=%0d seg=%h required=79", ok, seg);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    int e0;
    logic [6:0] lz;
`ifdef SSD_LZ_BLANK_EN
    lz = 7'h7F;
`else
    lz = 7'h40;
`endif
    e0 = errs;
    beat(8'h81, 4'h5, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (errs - e0 !== 1) begin
      failures++;
      $display("FAIL nonhot_err got=%0d required=1", errs - e0);
    end
    e0 = errs;
    send_frame(32'h000000A0, 1'b1, 3);
    checks++;
    if (errs - e0 !== 0) begin
      failures++;
      $display("FAIL gap_no_err got=%0d required=0", errs - e0);
    end
    wait_slot(1, ok);
    checks++;
    if (!ok || seg !== 7'h08) begin
      failures++;
      $display("FAIL gap_slot1 ok=%0d seg=%h required=08", ok, seg);
    end
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h40) begin
      failures++;
      $display("FAIL gap_slot0 ok=%0d seg=%h required=40", ok, seg);
    end
    for (int k = 2; k < 8; k++) begin
      wait_slot(k, ok);
      checks++;
      if (!ok || seg !== lz) begin
        failures++;
        $display("FAIL lz_slot%0d ok=%0d seg=%h required=%h", k, ok, seg, lz);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ssd_en       = 8'h80;
    display_char = 4'h7;
    @(negedge clk);
    idle();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an=%h seg=%h valid=%b required=FF 7F 0",
               an, seg, frame_valid);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (an !== 8'hFF || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset an=%h valid=%b required=FF 0", an, frame_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    errs     = 0;
    n_rst    = 1'b0;
    idle();
    test_reset();
    test_frame();
    test_bad_index();
    test_no_strobe();
    test_restart();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
